// File: rtl/fx_stream_ctrl.sv
// Job sequencer for the fixed-latency f(x) floating-point datapath: feeds samples,
// stalls the whole pipeline under output backpressure and tags the last result.
module fx_stream_ctrl #(
  parameter int unsigned LATENCY = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] n,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  output logic [31:0]        pipe_x,
  output logic               pipe_en,
  output logic               pipe_areset,
  input  logic [31:0]        pipe_result,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_data,
  output logic               m_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [COUNT_W-1:0] r_n;
  logic [COUNT_W-1:0] r_issued;
  logic [COUNT_W-1:0] r_retired;
  logic [LATENCY-1:0] r_vsr;
  logic               w_issue;
  logic               w_retire;
  logic               w_start;
  logic               w_last_issue;
  logic               w_last_retire;

  // Only a finished result that cannot leave freezes the datapath, so m_ready
  // feeds pipe_en and s_ready combinationally.
  assign m_valid     = r_vsr[LATENCY-1];
  assign pipe_en     = !(m_valid && !m_ready);
  assign s_ready     = (r_state == S_RUN) && pipe_en;
  assign w_issue     = s_valid && s_ready;
  assign w_retire    = m_valid && m_ready;
  assign w_start     = (r_state == S_IDLE) && start;

  assign w_last_issue  = (r_issued  + COUNT_W'(1)) == r_n;
  assign w_last_retire = (r_retired + COUNT_W'(1)) == r_n;

  assign m_last      = m_valid && (r_retired == (r_n - COUNT_W'(1)));
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign pipe_x      = s_data;
  assign m_data      = pipe_result;
  assign pipe_areset = ~reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (n != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_issue && w_last_issue) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_retire && w_last_retire) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n       <= '0;
      r_issued  <= '0;
      r_retired <= '0;
    end else if (w_start) begin
      r_n       <= n;
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      if (w_issue) begin
        r_issued <= r_issued + COUNT_W'(1);
      end
      if (w_retire) begin
        r_retired <= r_retired + COUNT_W'(1);
      end
    end
  end

  // Token tracker advances in lockstep with the datapath enable; zeros are bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsr <= '0;
    end else if (pipe_en) begin
      r_vsr <= {r_vsr[LATENCY-2:0], w_issue};
    end
  end

endmodule

// File: doc/fx_stream_ctrl.md
# fx_stream_ctrl

Streaming sequencer for the f(x) = 0.5·x + x²·cos((x−128)/128) floating-point pipeline. It accepts a job of N single-precision samples on a valid/ready input stream and feeds them into the fixed-latency datapath. It drives the datapath's clock enable to stall the whole pipeline under output backpressure, tracks in-flight tokens with a valid shift register, and presents results on a valid/ready output stream. It also tags the last result and pulses `done` at the end of the job.

## Interface
- `LATENCY`, 16: datapath latency in enabled clock cycles, ≥2; must match the attached datapath exactly.
- `COUNT_W`, 16: width of the job-length and element counters.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); all state clears immediately.
- `start`  in  1  job request; sampled only in IDLE.
- `n`  in  COUNT_W  job length, latched on accepted `start`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at job end.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  controller accepts sample this cycle.
- `s_data`  in  32  IEEE-754 single sample x.
- `pipe_x`  out  32  datapath input; equals `s_data` combinationally.
- `pipe_en`  out  1  datapath clock enable.
- `pipe_areset`  out  1  active-high datapath reset = ~`reset`.
- `pipe_result`  in  32  datapath output.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts result.
- `m_data`  out  32  equals `pipe_result`.
- `m_last`  out  1  high with the Nth result of the job.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE: `start`=1 latches `n` and clears `issued` and `retired`.
  - n≠0 → RUN.
  - n=0 → DONE; no samples are consumed and no results are produced.
- RUN → DRAIN when a sample issues and `issued`+1 = n.
- DRAIN → DONE on the cycle in which an output handshake makes `retired`+1 = n.
- DONE → IDLE unconditionally. `done`=1 only in DONE.
- `start` outside IDLE is ignored; `n` changes after latching are ignored.
- Valid shift register `vsr[LATENCY-1:0]`:
  - `m_valid` = `vsr[LATENCY-1]`.
  - It shifts only when `pipe_en`=1; `vsr[0]` takes `issue`.
- `pipe_en` = !(`m_valid` && !`m_ready`). The pipeline freezes only while a finished result is blocked. The combinational path from `m_ready` is intentional.
- `s_ready` = (state==RUN) && `pipe_en`.
- `issue` = `s_valid` && `s_ready`; `issued` increments on each issue.
- Cycles in RUN with no issue insert bubbles (vsr bit 0). Bubbles are never presented on `m_valid`.
- Output handshake = `m_valid` && `m_ready`; `retired` increments on each handshake.
- `m_last` = `m_valid` && (`retired` = n−1).
- Results leave in issue order; no reordering or dropping.
- Counters are COUNT_W wide. Maximum job length is 2^COUNT_W−1; no wrap occurs within a job.
- A new job is issued only after DONE. The pipeline is therefore empty at each job start.

## Timing
- Reset values: `busy`=0, `done`=0, `s_ready`=0, `m_valid`=0, `m_last`=0, `vsr`=0, counters=0. `pipe_en`=1 while in reset (no valid tokens). `pipe_areset`=1.
- Latency with no stalls: a sample issued in cycle t gives `m_valid`=1 in cycle t+LATENCY. Throughput is one sample per cycle.
- Each stalled cycle (`m_valid`=1, `m_ready`=0) adds one cycle to every in-flight token. `m_data`, `m_valid` and `m_last` are held stable during the stall.
- `start` accepted in cycle t → `busy`=1 and `s_ready` can be 1 from t+1.
- Last handshake in cycle c → `done`=1 and `busy`=0 in c+1 → IDLE in c+2. The earliest next `start` is accepted in c+2.
- n=0: `start` in t → `done`=1 in t+1; `busy` stays 0.
- When `s_valid`=1 and a stall occur together, the sample is not consumed (`s_ready`=0) and the source must hold it.
- Reset asserted mid-job:
  - All outputs return to their reset values asynchronously.
  - In-flight tokens are discarded.
  - No `done` pulse is generated.

## Test plan
- Reset/idle: assert `reset`=0 mid-RUN with 3 tokens in flight → `m_valid`, `busy` and `s_ready` drop to 0 at once; after release, IDLE with no stray `m_valid`.
- Streaming, LATENCY=4 bench delay model: `start` with n=5, `s_valid` held high with x=1.0..5.0 and `m_ready`=1 → 5 issues in consecutive cycles; results in order 4 cycles later; `m_last` on the 5th; `done` one cycle after.
- Backpressure: n=4, `m_ready`=0 for 3 cycles when the 2nd result appears → `pipe_en`=0 and `s_ready`=0 for exactly those cycles; `m_data` held; all 4 results delivered in order, none duplicated.
- Bubbles: n=3 with `s_valid` pattern 1,0,0,1,1 → `m_valid` pattern mirrors it LATENCY cycles later, with gaps; `retired`=3 at `done`.
- Edge cases:
  - n=0 → `done` the next cycle, zero `s_ready`.
  - `start` pulsed during RUN → ignored; job length unchanged.
- Integration with real datapath and LATENCY set to its true value: x=0x43000000 (128.0) → `m_data`=0x46808000 (16448.0); x=0x00000000 → 0x00000000.
